// File: rtl/upc_pkg.sv
// rtl/upc_pkg.sv - shared types, frame constants and parity helper for the UPC record transmitter
package upc_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int FRAME_BITS = 7;
  localparam int DATA_BITS  = 4;

  // Even parity: data plus parity always carries an even count of ones
  function automatic logic upc_parity(input logic u, input logic p, input logic c, input logic m);
    return u ^ p ^ c ^ m;
  endfunction

endpackage

// File: rtl/upc_frame_tx_bit_timer.sv
// rtl/upc_frame_tx_bit_timer.sv - per-bit cycle counter; expire marks the last cycle of each frame bit
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic expire
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [W-1:0] cnt;

  assign expire = (cnt == W'(CLKS_PER_BIT - 1));

  // Wrapping on expire is what clears the count at every bit boundary
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/upc_frame_tx.sv
// rtl/upc_frame_tx.sv - serialises one {U,P,C,M} record per handshake as start, 4 data, even parity, stop
module upc_frame_tx
  import upc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] upc,
  input  logic       mark,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  tx_state_t  state, state_nx;
  logic [3:0] shreg, shreg_nx;
  logic       par, par_nx;
  logic [1:0] idx, idx_nx;
  logic       tx_nx;
  logic       accept;
  logic       expire;

  assign in_ready   = (state == IDLE);
  assign accept     = in_valid && in_ready;
  assign frame_done = (state == STOP) && expire;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .expire (expire)
  );

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    par_nx   = par;
    idx_nx   = idx;
    tx_nx    = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = START;
          shreg_nx = {upc, mark};
          par_nx   = upc_parity(upc[2], upc[1], upc[0], mark);
          idx_nx   = 2'd0;
        end
      end
      START:  if (expire) state_nx = DATA;
      DATA: begin
        if (expire) begin
          shreg_nx = {shreg[2:0], 1'b0};
          idx_nx   = idx + 2'd1;
          if (idx == 2'(DATA_BITS - 1)) state_nx = PARITY;
        end
      end
      PARITY: if (expire) state_nx = STOP;
      STOP:   if (expire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // tx is registered from the upcoming state so the line changes on the bit edge itself
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg_nx[3];
      PARITY:  tx_nx = par_nx;
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      shreg <= '0;
      par   <= 1'b0;
      idx   <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      par   <= par_nx;
      idx   <= idx_nx;
      tx    <= tx_nx;
      busy  <= (state_nx != IDLE);
    end
  end

endmodule
